// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter_n
//  Description : N-digit packed-BCD up/down counter with enable tick, parallel
//                load, synchronous clear, wrap/saturate and a registered tc.
//  Revision    : 1.0  - initial release
// ============================================================================
module bcd_counter_n #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                up,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                at_max,
    output logic                at_min
);

    localparam bit c_SATURATE = (WRAP == 1'b0);

    logic [4*DIGITS-1:0] r_count;
    logic                r_tc;
    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;
    logic [4*DIGITS-1:0] w_load;
    // w_low9[i] / w_low0[i]: every digit below i is 9 / 0 (bit DIGITS covers all)
    logic [DIGITS:0]     w_low9;
    logic [DIGITS:0]     w_low0;
    logic                w_term;
    logic                w_hold;

    assign w_low9[0] = 1'b1;
    assign w_low0[0] = 1'b1;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] w_d;
        logic [3:0] w_ld;

        assign w_d  = r_count[4*gi +: 4];
        assign w_ld = load_val[4*gi +: 4];

        assign w_low9[gi+1] = w_low9[gi] & (w_d == 4'd9);
        assign w_low0[gi+1] = w_low0[gi] & (w_d == 4'd0);

        assign w_inc[4*gi +: 4] = !w_low9[gi]   ? w_d  :
                                  (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
        assign w_dec[4*gi +: 4] = !w_low0[gi]   ? w_d  :
                                  (w_d == 4'd0) ? 4'd9 : w_d - 4'd1;
        assign w_load[4*gi +: 4] = (w_ld > 4'd9) ? 4'd9 : w_ld;
    end

    assign at_max = w_low9[DIGITS];
    assign at_min = w_low0[DIGITS];
    assign w_term = up ? at_max : at_min;
    assign w_hold = c_SATURATE & w_term;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load;
            r_tc    <= 1'b0;
        end else if (en) begin
            // tc flags the terminal value even when saturating
            r_tc <= w_term;
            if (!w_hold) begin
                r_count <= up ? w_inc : w_dec;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;

endmodule
`default_nettype wire
